// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
module mul_div_unit #(
  parameter int NUM_BITS = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                start,
  input  logic [1:0]          md_op,
  input  logic [NUM_BITS-1:0] data1,
  input  logic [NUM_BITS-1:0] data2,
  input  logic                flush,
  input  logic                hi_wr,
  input  logic                lo_wr,
  input  logic [NUM_BITS-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] hi,
  output logic [NUM_BITS-1:0] lo
);

  localparam int N = NUM_BITS;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                is_div;
  logic                neg_a;
  logic                neg_b;
  logic [N-1:0]        opa;
  logic [N-1:0]        opb;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient/dividend}.
  logic [2*N-1:0]      acc;

  logic                signed_op;
  logic                start_neg_a;
  logic                start_neg_b;
  logic [N-1:0]        data1_mag;
  logic [N-1:0]        data2_mag;
  logic [N:0]          mul_sum;
  logic [2*N-1:0]      mul_next;
  logic [N:0]          div_shift;
  logic [N:0]          div_diff;
  logic [2*N-1:0]      div_next;
  logic [2*N-1:0]      prod_fix;
  logic [N-1:0]        hi_fix;
  logic [N-1:0]        lo_fix;

  always_comb begin
    signed_op   = ~md_op[0];
    start_neg_a = signed_op & data1[N-1];
    start_neg_b = signed_op & data2[N-1];
    data1_mag   = start_neg_a ? -data1 : data1;
    data2_mag   = start_neg_b ? -data2 : data2;

    mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opa : {N{1'b0}})};
    mul_next = {mul_sum, acc[N-1:1]};

    // div_diff[N] set means the trial subtraction went negative: restore.
    div_shift = acc[2*N-1:N-1];
    div_diff  = div_shift - {1'b0, opb};
    if (!div_diff[N]) div_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
    else              div_next = {div_shift[N-1:0], acc[N-2:0], 1'b0};

    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    hi_fix   = prod_fix[2*N-1:N];
    lo_fix   = prod_fix[N-1:0];
    if (is_div) begin
      if (opb == '0) begin
        // Divide by zero reports the original dividend bits, rebuilt from its magnitude.
        lo_fix = {N{1'b1}};
        hi_fix = neg_a ? -opa : opa;
      end else begin
        lo_fix = (neg_a ^ neg_b) ? -acc[N-1:0] : acc[N-1:0];
        hi_fix = neg_a ? -acc[2*N-1:N] : acc[2*N-1:N];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_wr) hi <= wr_data;
          if (lo_wr) lo <= wr_data;
          if (start && !flush) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= md_op[1];
            neg_a  <= start_neg_a;
            neg_b  <= start_neg_b;
            opa    <= data1_mag;
            opb    <= data2_mag;
            acc    <= {{N{1'b0}}, (md_op[1] ? data1_mag : data2_mag)};
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_BITS'(1);
            if (cnt == CNT_BITS'(N - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit placed beside the combinational ALU in the execute stage.
- Computes signed and unsigned MULT, MULTU, DIV and DIVU over NUM_BITS-bit operands, one bit per clock, and holds results in architectural HI/LO registers.
- Provides a start/busy/done handshake so the pipeline can stall on reads of HI/LO. Also supports direct HI/LO writes (move-to) and a pipeline flush.

Parameters:
- NUM_BITS, 32, operand/result width; must be at least 4.
- CNT_BITS, 6, iteration counter width; must satisfy 2**CNT_BITS > NUM_BITS.

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  asynchronous active-low reset.
- start  input  1  operation request; sampled only while idle.
- md_op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- data1  input  NUM_BITS  multiplicand / dividend.
- data2  input  NUM_BITS  multiplier / divisor.
- flush  input  1  abort any in-flight operation.
- hi_wr  input  1  write wr_data into HI (move-to-HI).
- lo_wr  input  1  write wr_data into LO (move-to-LO).
- wr_data  input  NUM_BITS  data for hi_wr/lo_wr.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO updated this cycle.
- hi  output  NUM_BITS  HI register: product upper half, or remainder.
- lo  output  NUM_BITS  LO register: product lower half, or quotient.

Behaviour:
- Reset (rst_ low, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand and accumulator registers cleared.
- States:
  - IDLE: start=1 and flush=0 -> CALC. At this edge, latch md_op and operand magnitudes; record sign flags, which are used only for signed ops.
  - CALC: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle. After NUM_BITS steps -> FIX. flush=1 -> IDLE.
  - FIX: apply sign correction. On this edge, write hi/lo, pulse done, deassert busy, -> IDLE. flush=1 here -> IDLE, no write.
- busy: 1 in CALC and FIX, otherwise 0.
- Latency: start accepted at edge E0. hi, lo and done update at edge E0+NUM_BITS+1. done is high for exactly that one cycle.
- Back-to-back: a start held during the done cycle is accepted, since the unit is IDLE then.
- start while busy: ignored; no queuing.
- Multiply results:
  - Result is the full 2*NUM_BITS product, hi = upper half, lo = lower half.
  - Signed: product of the magnitudes, negated when the operand signs differ.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Signed overflow (most-negative value / -1): lo = most-negative value, hi = 0.
  - Divisor zero, signed or unsigned: lo = all ones, hi = data1 as latched (raw, not the magnitude). The unit still takes full latency.
- HI/LO direct writes:
  - hi_wr/lo_wr take effect only while IDLE and not on a done edge; they are ignored while busy.
  - hi_wr and lo_wr may be asserted together.
  - hi_wr/lo_wr with start in the same cycle: the write lands and the operation starts; its result later overwrites hi/lo.
- flush: takes priority over start and over completion. hi/lo keep their prior values, no done pulse, busy=0 next cycle.
- Reset mid-operation: immediate clear to the reset state; no done.
- Operands are not required to be held after the start edge.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at E0+33, hi=0xFFFFFFFE, lo=0x00000001, busy high for cycles E0+1..E0+32.
- MULT -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV -7/2 back-to-back in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 9/2 with hi=lo=0x12345678 preloaded via hi_wr/lo_wr; pulse flush at E0+10 -> busy=0 at E0+11, no done, hi/lo stay 0x12345678. Next DIVU 9/2 -> lo=4, hi=1.
- During MULTU 6x7: a second start with different operands at E0+5 is ignored, and hi_wr with 0xDEADBEEF at E0+6 is ignored -> hi=0, lo=42.
- Deassert rst_ at E0+12 of a MULT, between clock edges -> busy, done, hi and lo go to 0 immediately without waiting for clk. A later MULTU 2x3 after release -> lo=6.
